// File: rtl/zsdram_wr_arbiter.sv
// SDRAM write-port arbiter: NUM_REQ draw clients share one req/done write port,
// round-robin or fixed priority, with a watchdog that aborts writes that never finish.

module zsdram_wr_arbiter_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic win,
  input  logic finish,
  output logic grant,
  output logic done
);
  // Grant is held from the winning edge through RELEASE; done echoes grant for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= 1'b0;
      done  <= 1'b0;
    end else if (clear) begin
      grant <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      grant <= win;
    end else if (finish) begin
      done <= grant;
    end
  end
endmodule

module zsdram_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = 4095
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          iReq,
  input  logic [NUM_REQ*ADDR_W-1:0]   iAddr,
  input  logic [NUM_REQ*4*DATA_W-1:0] iData,
  output logic [NUM_REQ-1:0]          oDone,
  output logic [NUM_REQ-1:0]          oGrant,
  output logic [ADDR_W-1:0]           oSDRAM_Wr_Addr,
  output logic [DATA_W-1:0]           oSDRAM_Wr_Data1,
  output logic [DATA_W-1:0]           oSDRAM_Wr_Data2,
  output logic [DATA_W-1:0]           oSDRAM_Wr_Data3,
  output logic [DATA_W-1:0]           oSDRAM_Wr_Data4,
  output logic                        oSDRAM_Wr_Req,
  input  logic                        iSDRAM_Wr_Done,
  output logic                        oBusy,
  output logic                        oTimeout_Err,
  input  logic                        iErr_Clr
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]                          state;
  logic [15:0]                         timer;
  logic [IDX_W-1:0]                    rrPtr;
  logic [IDX_W-1:0]                    gIdx;
  logic [IDX_W-1:0]                    winIdx;
  logic [IDX_W:0]                      cand;
  logic                                found;
  logic [NUM_REQ-1:0]                  winOH;
  logic [NUM_REQ-1:0][ADDR_W-1:0]      addrArr;
  logic [NUM_REQ-1:0][3:0][DATA_W-1:0] dataArr;
  logic [3:0][DATA_W-1:0]              wrData;
  logic                                start;
  logic                                doneEvt;
  logic                                toEvt;
  logic                                finish;
  logic                                clear;

  genvar k;
  generate
    for (k = 0; k < NUM_REQ; k++) begin : g_slot
      assign addrArr[k] = iAddr[k*ADDR_W +: ADDR_W];
      assign dataArr[k] = iData[k*4*DATA_W +: 4*DATA_W];
      assign winOH[k]   = (winIdx == IDX_W'(k));

      zsdram_wr_arbiter_slot u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .load   (start),
        .win    (winOH[k]),
        .finish (finish),
        .grant  (oGrant[k]),
        .done   (oDone[k])
      );
    end
  endgenerate

  // Search starts one past the last winner; the extra cand bit absorbs the wrap.
  always_comb begin
    found  = 1'b0;
    winIdx = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (FIXED_PRIO) begin
        cand = (IDX_W+1)'(i);
      end else begin
        cand = {1'b0, rrPtr} + (IDX_W+1)'(i + 1);
        if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && iReq[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winIdx = cand[IDX_W-1:0];
      end
    end
  end

  assign start   = en && (state == S_IDLE) && found;
  assign doneEvt = en && (state == S_WAIT) && iSDRAM_Wr_Done;
  assign toEvt   = en && (state == S_WAIT) && !iSDRAM_Wr_Done && (timer == TMO_LAST);
  assign finish  = doneEvt || toEvt;
  assign clear   = !en || (state == S_RELEASE);
  assign oBusy   = (state != S_IDLE);

  assign oSDRAM_Wr_Data1 = wrData[0];
  assign oSDRAM_Wr_Data2 = wrData[1];
  assign oSDRAM_Wr_Data3 = wrData[2];
  assign oSDRAM_Wr_Data4 = wrData[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      timer          <= '0;
      rrPtr          <= IDX_W'(NUM_REQ - 1);
      gIdx           <= '0;
      oSDRAM_Wr_Req  <= 1'b0;
      oSDRAM_Wr_Addr <= '0;
      wrData         <= '0;
    end else if (!en) begin
      // Abort keeps rrPtr so fairness survives an enable toggle.
      state         <= S_IDLE;
      timer         <= '0;
      oSDRAM_Wr_Req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            gIdx           <= winIdx;
            oSDRAM_Wr_Addr <= addrArr[winIdx];
            wrData         <= dataArr[winIdx];
            oSDRAM_Wr_Req  <= 1'b1;
            timer          <= '0;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          timer <= timer + 16'd1;
          if (finish) begin
            oSDRAM_Wr_Req <= 1'b0;
            rrPtr         <= gIdx;
            state         <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          timer <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        oTimeout_Err <= 1'b0;
    else if (iErr_Clr) oTimeout_Err <= 1'b0;
    else if (toEvt)    oTimeout_Err <= 1'b1;
  end
endmodule

// File: tb/tb_zsdram_wr_arbiter.sv
// Randomized scoreboard bench for zsdram_wr_arbiter: a round-robin instance checked
// against a transaction-level model, plus a fixed-priority instance with a directed run.

module tb_zsdram_wr_arbiter;
  localparam int N    = 4;
  localparam int AW   = 24;
  localparam int DW   = 16;
  localparam int TMO  = 16;
  localparam int RAND = -99;

  typedef struct {
    int             c;
    logic [AW-1:0]  a;
    logic [63:0]    d;
    int             lat;
    bit             to;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b1;
  logic            errClr = 1'b0;
  logic [N-1:0]    iReq = '0;
  logic [N-1:0]    fpReq = '0;
  logic [N*AW-1:0] iAddr = '0;
  logic [N*64-1:0] iData = '0;
  logic            wrDone = 1'b0;
  logic            fpWrDone = 1'b0;

  logic [N-1:0]    oDone, oGrant, fpDoneO, fpGrant;
  logic [AW-1:0]   wrAddr, fpAddr;
  logic [DW-1:0]   d1, d2, d3, d4, fd1, fd2, fd3, fd4;
  logic            wrReq, busy, tErr, fpWrReq, fpBusy, fpErr;

  int   nChk = 0;
  int   nFail = 0;
  int   nExp = 0;
  int   doneCnt = 0;
  int   modelPtr = N - 1;
  bit   monOn = 1'b1;
  bit   respOn = 1'b1;
  txn_t expQ[$];
  int   respQ[$];
  logic [N-1:0] fpOrder[$];
  logic [AW-1:0] cA[N];
  logic [63:0]   cD[N];

  zsdram_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0), .TIMEOUT(TMO)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .iReq(iReq), .iAddr(iAddr), .iData(iData),
    .oDone(oDone), .oGrant(oGrant), .oSDRAM_Wr_Addr(wrAddr),
    .oSDRAM_Wr_Data1(d1), .oSDRAM_Wr_Data2(d2), .oSDRAM_Wr_Data3(d3), .oSDRAM_Wr_Data4(d4),
    .oSDRAM_Wr_Req(wrReq), .iSDRAM_Wr_Done(wrDone), .oBusy(busy),
    .oTimeout_Err(tErr), .iErr_Clr(errClr)
  );

  zsdram_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1), .TIMEOUT(TMO)) u_fp (
    .clk(clk), .rst_n(rst_n), .en(en), .iReq(fpReq), .iAddr(iAddr), .iData(iData),
    .oDone(fpDoneO), .oGrant(fpGrant), .oSDRAM_Wr_Addr(fpAddr),
    .oSDRAM_Wr_Data1(fd1), .oSDRAM_Wr_Data2(fd2), .oSDRAM_Wr_Data3(fd3), .oSDRAM_Wr_Data4(fd4),
    .oSDRAM_Wr_Req(fpWrReq), .iSDRAM_Wr_Done(fpWrDone), .oBusy(fpBusy),
    .oTimeout_Err(fpErr), .iErr_Clr(errClr)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // SDRAM controller model: done after a planned latency, or never (timeout case).
  int rLat, rN;
  initial forever begin
    @(negedge clk);
    if (respOn && wrReq) begin
      rLat = (respQ.size() == 0) ? -1 : respQ.pop_front();
      if (rLat >= 0) begin
        repeat (rLat) @(negedge clk);
        wrDone = 1'b1;
        @(negedge clk);
        wrDone = 1'b0;
      end else begin
        rN = 0;
        while (wrReq && rN < 100) begin
          @(negedge clk);
          rN++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (fpWrReq) begin
      repeat (2) @(negedge clk);
      fpWrDone = 1'b1;
      @(negedge clk);
      fpWrDone = 1'b0;
    end
  end

  logic fpPrev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (fpWrReq && !fpPrev) fpOrder.push_back(fpGrant);
    fpPrev = fpWrReq;
  end

  // Monitor: pops an expected transaction on each new write request.
  txn_t         cur;
  int           mCnt = 0;
  logic         mPrevReq = 1'b0;
  logic [N-1:0] mPrevDone = '0;
  initial forever begin
    @(negedge clk);
    if (monOn) begin
      if (wrReq && !mPrevReq) begin
        if (expQ.size() == 0) begin
          chk("unexpected_req", 64'(expQ.size()), 64'(1));
        end else begin
          cur = expQ.pop_front();
          chk("grant", 64'(oGrant), 64'(1 << cur.c));
          chk("addr", 64'(wrAddr), 64'(cur.a));
          chk("data", {d4, d3, d2, d1}, cur.d);
          chk("busy", 64'(busy), 64'(1));
        end
        mCnt = 1;
      end else if (wrReq) begin
        mCnt++;
        chk("hold_addr", 64'(wrAddr), 64'(cur.a));
        chk("hold_data", {d4, d3, d2, d1}, cur.d);
      end
      if (!wrReq && mPrevReq)
        chk("req_cycles", 64'(mCnt), 64'(cur.to ? TMO : cur.lat + 1));
      if (oDone != '0) begin
        chk("done", 64'(oDone), 64'(1 << cur.c));
        chk("err_at_done", 64'(tErr), 64'(cur.to));
        doneCnt++;
      end
      if (mPrevDone != '0) chk("done_width", 64'(oDone), 64'(0));
    end
    mPrevReq  = wrReq;
    mPrevDone = oDone;
  end

  // One round: clients in mask request together and each drops after its done.
  // Model: round-robin serves them in circular order starting after the last winner.
  task automatic runRound(input logic [N-1:0] mask, input int latFix, input bit midChg, input int fixA);
    txn_t t;
    int   c, last, n, reqSeen;
    last = modelPtr;
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        cA[k] = (fixA >= 0) ? AW'(fixA) : AW'($urandom);
        cD[k] = {$urandom, $urandom};
        iAddr[k*AW +: AW] = cA[k];
        iData[k*64 +: 64] = cD[k];
      end
    end
    for (int i = 1; i <= N; i++) begin
      c = (modelPtr + i) % N;
      if (mask[c[1:0]]) begin
        t.c = c;
        t.a = cA[c];
        t.d = cD[c];
        if (latFix != RAND) t.lat = latFix;
        else t.lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
        t.to = (t.lat < 0);
        expQ.push_back(t);
        respQ.push_back(t.lat);
        nExp++;
        last = c;
      end
    end
    modelPtr = last;
    iReq = mask;
    @(negedge clk);
    chk("req_latency", 64'(wrReq), 64'(1));
    n = 0;
    reqSeen = 0;
    while (!(iReq == '0 && !busy) && n < 400) begin
      if (midChg && wrReq) begin
        reqSeen++;
        if (reqSeen == 3) begin
          iAddr[AW +: AW] = ~cA[1];
          iData[64 +: 64] = ~cD[1];
          iReq[1] = 1'b0;
        end
      end
      for (int k = 0; k < N; k++) if (oDone[k]) iReq[k] = 1'b0;
      errClr = (oDone != '0) && tErr;
      @(negedge clk);
      n++;
    end
    errClr = 1'b0;
    chk("round_finished", 64'(n < 400), 64'(1));
  endtask

  logic [N-1:0] fpExp[3] = '{4'b0010, 4'b0010, 4'b1000};

  initial begin
    int n, fpServed1;
    repeat (3) @(negedge clk);
    chk("inreset_req", 64'(wrReq), 64'(0));
    chk("inreset_grant", 64'(oGrant), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req", 64'(wrReq), 64'(0));
    chk("rst_grant", 64'(oGrant), 64'(0));
    chk("rst_done", 64'(oDone), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(tErr), 64'(0));
    chk("rst_addr", 64'(wrAddr), 64'(0));
    chk("rst_data", {d4, d3, d2, d1}, 64'(0));

    runRound(4'b0001, 4, 1'b0, 32'h00_1234);
    runRound(4'b1111, RAND, 1'b0, -1);
    runRound(4'b1111, RAND, 1'b0, -1);
    runRound(4'b0010, 6, 1'b1, -1);
    runRound(4'b0100, TMO - 1, 1'b0, -1);
    runRound(4'b1001, -1, 1'b0, -1);
    repeat (30) runRound(4'($urandom_range(1, 15)), RAND, 1'b0, -1);
    chk("sb_empty", 64'(expQ.size()), 64'(0));
    chk("done_count", 64'(doneCnt), 64'(nExp));

    // Enable dropped mid-WAIT, then restart with the request still held.
    monOn  = 1'b0;
    respOn = 1'b0;
    iAddr[AW +: AW] = 24'hAB_CDEF;
    iReq = 4'b0010;
    n = 0;
    while (!wrReq && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("en_req_seen", 64'(wrReq), 64'(1));
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_req", 64'(wrReq), 64'(0));
    chk("en_grant", 64'(oGrant), 64'(0));
    chk("en_done", 64'(oDone), 64'(0));
    chk("en_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("en_done2", 64'(oDone), 64'(0));
    en = 1'b1;
    @(negedge clk);
    chk("restart_req", 64'(wrReq), 64'(1));
    chk("restart_grant", 64'(oGrant), 64'(4'b0010));
    chk("restart_addr", 64'(wrAddr), 64'(24'hAB_CDEF));
    n = 0;
    while (oDone == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_done", 64'(oDone), 64'(4'b0010));
    chk("to_err", 64'(tErr), 64'(1));
    iReq = '0;
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(tErr), 64'(1));
    errClr = 1'b1;
    @(negedge clk);
    chk("err_clr", 64'(tErr), 64'(0));

    // Clear held across the expiry edge must win over the set.
    iReq = 4'b0100;
    n = 0;
    while (oDone == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("clr_prio_done", 64'(oDone), 64'(4'b0100));
    chk("clr_prio_err", 64'(tErr), 64'(0));
    iReq = '0;
    errClr = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed priority: client1 keeps requesting, client3 waits until it stops.
    fpReq = 4'b1010;
    n = 0;
    fpServed1 = 0;
    while ((fpReq != '0 || fpBusy) && n < 300) begin
      if (fpDoneO[1]) begin
        fpServed1++;
        if (fpServed1 == 2) fpReq[1] = 1'b0;
      end
      if (fpDoneO[3]) fpReq[3] = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("fp_finished", 64'(n < 300), 64'(1));
    chk("fp_count", 64'(fpOrder.size()), 64'(3));
    for (int i = 0; i < 3; i++)
      chk("fp_order", 64'((i < fpOrder.size()) ? fpOrder[i] : 4'hF), 64'(fpExp[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
